// File: rtl/systolic_drain.sv
// systolic_drain
//   Output-side collector for the systolic array. It removes the column skew from the
//   south-edge partial-sum bus. Column j lags column 0 by j cycles. The block buffers the
//   aligned rows in a FIFO and hands them downstream over valid/ready. The input is never
//   back-pressured. A row that arrives while the FIFO is full is dropped, and the sticky
//   overflow flag is set.
//
//   Optional feature: define DRAIN_RELU_EN to clamp negative lanes to zero before the
//   FIFO write. The ReLU is combinational and adds no latency.
//
// Parameters:
//   COL        number of array columns (>=2)
//   ACC_WIDTH  bits per column result, two's complement
//   DEPTH      FIFO entries, power of 2, >=2
//   TILE_ROWS  rows per tile; out_last marks the last row of each tile
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   in_valid   row-start strobe, aligned with lane 0 data
//   in_b       south-edge bus; lane j = in_b[ACC_WIDTH*j +: ACC_WIDTH]
//   out_valid  FIFO head valid
//   out_ready  downstream accept
//   out_data   aligned head row (zero when out_valid is low); same lane mapping as in_b
//   out_last   head row is the last row of a tile
//   overflow   sticky; a row was dropped (cleared only by rst)
//   level      FIFO occupancy
module systolic_drain #(
  parameter int COL       = 4,
  parameter int ACC_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int TILE_ROWS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [COL*ACC_WIDTH-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COL*ACC_WIDTH-1:0]   out_data,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [COL*ACC_WIDTH-1:0] row;
  logic [COL*ACC_WIDTH-1:0] wdata;
  logic [COL-2:0]           vchain;

  // Deskew: lane j is delayed COL-1-j cycles, so every lane of a row lines up in the
  // cycle when lane COL-1 arrives.
  for (genvar j = 0; j < COL; j++) begin : g_lane
    localparam int unsigned D = COL - 1 - j;
    if (D == 0) begin : g_direct
      assign row[ACC_WIDTH*j +: ACC_WIDTH] = in_b[ACC_WIDTH*j +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= in_b[ACC_WIDTH*j +: ACC_WIDTH];
          for (int unsigned k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign row[ACC_WIDTH*j +: ACC_WIDTH] = sr[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vchain <= '0;
    end else begin
      vchain[0] <= in_valid;
      for (int unsigned k = 1; k < COL-1; k++) vchain[k] <= vchain[k-1];
    end
  end

`ifdef DRAIN_RELU_EN
  function automatic logic [COL*ACC_WIDTH-1:0] relu(input logic [COL*ACC_WIDTH-1:0] r);
    logic [COL*ACC_WIDTH-1:0] o;
    o = r;
    for (int unsigned k = 0; k < COL; k++) begin
      if (r[ACC_WIDTH*k + ACC_WIDTH - 1]) o[ACC_WIDTH*k +: ACC_WIDTH] = '0;
    end
    return o;
  endfunction

  assign wdata = relu(row);
`else
  assign wdata = row;
`endif

  logic [COL*ACC_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic [LW-1:0]            lvl;
  logic [CW-1:0]            tcnt;
  logic                     ovf;
  logic                     full;
  logic                     push_req;
  logic                     push;
  logic                     pop;

  assign full     = (lvl == LW'(DEPTH));
  assign out_valid = (lvl != '0);
  assign pop      = out_valid && out_ready;
  assign push_req = vchain[COL-2];
  // While the FIFO is full, a pop in the same cycle frees the head slot. The write then
  // goes to that slot (wptr == rptr), and the old head has already been read this cycle.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      tcnt <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        if (tcnt == CW'(TILE_ROWS-1)) tcnt <= '0;
        else                          tcnt <= tcnt + CW'(1);
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  assign out_data = out_valid ? mem[rptr] : '0;
  assign out_last = out_valid && (tcnt == CW'(TILE_ROWS-1));
  assign overflow = ovf;
  assign level    = lvl;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain (COL=4, ACC_WIDTH=16, DEPTH=8, TILE_ROWS=4).
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later, so every
// check shows the state that the previous rising edge left behind.
module tb_systolic_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  logic [15:0] lanes_tab [16][4];

  systolic_drain #(
    .COL(4),
    .ACC_WIDTH(16),
    .DEPTH(8),
    .TILE_ROWS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .overflow(overflow),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] b;
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [3:0]  elv;
    logic        eo;
  } vec_t;

  vec_t tab [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input logic iv, input logic [63:0] b, input logic rdy);
    in_valid = iv; in_b = b; out_ready = rdy;
    #1;
  endtask

  // Skewed bus for cycle c of a stream of n rows whose strobes start at cycle 0.
  function automatic logic [63:0] stream_b(input int c, input int n);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) begin
      if (c - j >= 0 && c - j < n) b[16*j +: 16] = lanes_tab[c-j][j];
    end
    return b;
  endfunction

  function automatic logic [63:0] row_of(input int r);
    return {lanes_tab[r][3], lanes_tab[r][2], lanes_tab[r][1], lanes_tab[r][0]};
  endfunction

  task automatic set_vec(input int i, input logic iv, input logic rdy, input logic ev,
                         input logic [63:0] ed, input logic el, input logic [3:0] elv);
    tab[i].iv = iv; tab[i].b = stream_b(i, 4); tab[i].rdy = rdy;
    tab[i].ev = ev; tab[i].ed = ed; tab[i].el = el; tab[i].elv = elv; tab[i].eo = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_b = '0; out_ready = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 4; j++) lanes_tab[r][j] = 16'(16'h0100 * (j + 1) + r);

    // Reset state
    do_reset();
    apply(1'b0, '0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_level", 64'(level), 64'd0);

    // Skew alignment: rows 0..3 strobed in cycles 0..3, out_ready held high
    set_vec(0, 1, 1, 0, 64'h0, 0, 0);
    set_vec(1, 1, 1, 0, 64'h0, 0, 0);
    set_vec(2, 1, 1, 0, 64'h0, 0, 0);
    set_vec(3, 1, 1, 0, 64'h0, 0, 0);
    set_vec(4, 0, 1, 1, 64'h0400_0300_0200_0100, 0, 1);
    set_vec(5, 0, 1, 1, 64'h0401_0301_0201_0101, 0, 1);
    set_vec(6, 0, 1, 1, 64'h0402_0302_0202_0102, 0, 1);
    set_vec(7, 0, 1, 1, 64'h0403_0303_0203_0103, 1, 1);
    set_vec(8, 0, 1, 0, 64'h0, 0, 0);
    set_vec(9, 0, 1, 0, 64'h0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      apply(tab[i].iv, tab[i].b, tab[i].rdy);
      chk($sformatf("skew_valid[%0d]", i), 64'(out_valid), 64'(tab[i].ev));
      chk($sformatf("skew_data[%0d]", i), out_data, tab[i].ed);
      chk($sformatf("skew_last[%0d]", i), 64'(out_last), 64'(tab[i].el));
      chk($sformatf("skew_level[%0d]", i), 64'(level), 64'(tab[i].elv));
      chk($sformatf("skew_ovf[%0d]", i), 64'(overflow), 64'(tab[i].eo));
      @(negedge clk);
    end

    // Back-pressure overflow: 9 rows with out_ready low, then drain.
    // The drain is also the tile-marking sequence.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply(c < 9, stream_b(c, 9), 1'b0);
      if (c == 11) begin
        chk("ovf_level8", 64'(level), 64'd8);
        chk("ovf_not_yet", 64'(overflow), 64'd0);
      end
      @(negedge clk);
    end
    apply(1'b0, '0, 1'b0);
    chk("ovf_level_hold", 64'(level), 64'd8);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head", out_data, row_of(0));
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      apply(1'b0, '0, 1'b1);
      chk($sformatf("ovf_pop_valid[%0d]", r), 64'(out_valid), 64'd1);
      chk($sformatf("ovf_pop_data[%0d]", r), out_data, row_of(r));
      chk($sformatf("tile_last[%0d]", r), 64'(out_last), 64'(r == 3 || r == 7));
      @(negedge clk);
    end
    apply(1'b0, '0, 1'b1);
    chk("ovf_empty_valid", 64'(out_valid), 64'd0);
    chk("ovf_empty_data", out_data, 64'd0);
    chk("ovf_empty_level", 64'(level), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    @(negedge clk);

    // Full plus simultaneous pop: the 9th push lands in the cycle that pops row 0
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply(c < 9, stream_b(c, 9), c == 11);
      if (c == 11) begin
        chk("fp_level_full", 64'(level), 64'd8);
        chk("fp_head", out_data, row_of(0));
      end
      @(negedge clk);
    end
    for (int r = 1; r <= 8; r++) begin
      apply(1'b0, '0, 1'b1);
      if (r == 1) begin
        chk("fp_level_kept", 64'(level), 64'd8);
        chk("fp_no_ovf", 64'(overflow), 64'd0);
      end
      chk($sformatf("fp_data[%0d]", r), out_data, row_of(r));
      chk($sformatf("fp_last[%0d]", r), 64'(out_last), 64'(r == 3 || r == 7));
      @(negedge clk);
    end
    apply(1'b0, '0, 1'b1);
    chk("fp_drained", 64'(out_valid), 64'd0);
    chk("fp_ovf_final", 64'(overflow), 64'd0);
    @(negedge clk);

    // Reset mid-operation: 3 rows in the FIFO and 2 in the skew pipeline at cycle 6
    do_reset();
    for (int c = 0; c < 7; c++) begin
      apply(c < 5, stream_b(c, 5), 1'b0);
      if (c == 6) begin
        chk("mid_level_pre", 64'(level), 64'd3);
        rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    apply(1'b0, '0, 1'b1);
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_data", out_data, 64'd0);
    chk("mid_level", 64'(level), 64'd0);
    chk("mid_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, '0, 1'b1);
      chk($sformatf("mid_quiet[%0d]", c), {out_valid, out_data}, 65'd0);
      @(negedge clk);
    end

    // ReLU
    do_reset();
    lanes_tab[0][0] = 16'hFF80;
    lanes_tab[0][1] = 16'h7FFF;
    lanes_tab[0][2] = 16'h8000;
    lanes_tab[0][3] = 16'h0001;
    for (int c = 0; c < 4; c++) begin
      apply(c < 1, stream_b(c, 1), 1'b0);
      @(negedge clk);
    end
    apply(1'b0, '0, 1'b0);
    chk("relu_valid", 64'(out_valid), 64'd1);
`ifdef DRAIN_RELU_EN
    chk("relu_data", out_data, 64'h0001_0000_7FFF_0000);
`else
    chk("relu_data", out_data, 64'h0001_8000_7FFF_FF80);
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
